// File: rtl/ppu_pkg.sv
// ppu_pkg -- definitions shared by the PPU-side blocks.
//   DMA_STATES_t  : OAM DMA controller states
//   OAM_BASE_ADDR : first byte of OAM in the CPU address map
//   DMA_REG_ADDR  : MMIO address of the DMA source-page register
//   dma_src_fold  : maps a requested source page onto the page actually read
package ppu_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_XFER
    } DMA_STATES_t;

    localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;

    // Pages E0h..FFh mirror C0h..DFh (echo RAM), so the DMA reads the mirror.
    function automatic logic [7:0] dma_src_fold(input logic [7:0] page);
        return (page >= 8'hE0) ? page - 8'h20 : page;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl -- OAM DMA engine. A CPU write to FF46 selects a source page
// and starts a copy of BYTES bytes from {page, 00h..} into OAM at FE00h.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   ADDR, WR, MMIO_DATA_out   : CPU MMIO address, write strobe, write data
//   MMIO_DATA_in              : register readback (FFh for other addresses)
//   DMA_RD, DMA_ADDR          : source read strobe and address
//   DMA_DATA_in               : source data, valid one clock after DMA_RD
//   OAM_WR, OAM_ADDR, OAM_DATA: OAM write strobe, address and data
//   DMA_ACTIVE                : high while bytes are being copied
//   DMA_DONE                  : one-clock pulse after the last byte is written
module oam_dma_ctrl
    import ppu_pkg::*;
#(
    parameter int BYTES        = 160,
    parameter int CYC_PER_BYTE = 4,
    parameter int START_DLY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  MMIO_DATA_in,
    output logic        DMA_RD,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DATA_in,
    output logic        OAM_WR,
    output logic [15:0] OAM_ADDR,
    output logic [7:0]  OAM_DATA,
    output logic        DMA_ACTIVE,
    output logic        DMA_DONE
);

    localparam int PH_W  = $clog2(CYC_PER_BYTE);
    localparam int DLY_W = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;

    localparam logic [PH_W-1:0]  PH_READ  = '0;
    localparam logic [PH_W-1:0]  PH_LATCH = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYC_PER_BYTE - 1);
    localparam logic [7:0]       IDX_LAST = 8'(BYTES - 1);
    localparam logic [DLY_W-1:0] DLY_END  = DLY_W'(START_DLY);

    DMA_STATES_t      state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       src_hi_q, src_hi_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       reg_q, reg_d;
    logic             done_q, done_d;

    logic trigger;
    logic final_wr;
    logic dma_rd;
    logic oam_wr;

    assign trigger  = WR && (ADDR == DMA_REG_ADDR);
    assign final_wr = (state_q == DMA_XFER) && (phase_q == PH_LAST) && (idx_q == IDX_LAST);
    assign reg_d    = trigger ? MMIO_DATA_out : reg_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case/if chain can leave one unassigned and infer a latch.
        state_d  = state_q;
        dly_d    = dly_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        src_hi_d = src_hi_q;
        data_d   = data_q;
        done_d   = 1'b0;
        dma_rd   = 1'b0;
        oam_wr   = 1'b0;

        case (state_q)
            DMA_IDLE: ;
            DMA_START: begin
                if (dly_q == DLY_END) begin
                    state_d = DMA_XFER;
                    phase_d = '0;
                    idx_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            DMA_XFER: begin
                dma_rd = (phase_q == PH_READ);
                if (phase_q == PH_LATCH) data_d = DMA_DATA_in;
                if (phase_q == PH_LAST) begin
                    oam_wr  = 1'b1;
                    phase_d = '0;
                    idx_d   = idx_q + 8'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = DMA_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = DMA_IDLE;
        endcase

        // A new trigger wins over everything: restart from START with the new
        // page. Only the very last write of a transfer is still allowed out,
        // but its DONE pulse is dropped.
        if (trigger) begin
            state_d  = DMA_START;
            dly_d    = '0;
            phase_d  = '0;
            idx_d    = '0;
            src_hi_d = dma_src_fold(MMIO_DATA_out);
            done_d   = 1'b0;
            dma_rd   = 1'b0;
            if (!final_wr) oam_wr = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DMA_IDLE;
            dly_q    <= '0;
            phase_q  <= '0;
            idx_q    <= '0;
            src_hi_q <= '0;
            data_q   <= '0;
            reg_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            src_hi_q <= src_hi_d;
            data_q   <= data_d;
            reg_q    <= reg_d;
            done_q   <= done_d;
        end
    end

    // Addresses and data are gated by their strobes so the buses sit at zero
    // whenever no access is in progress, including during reset.
    assign DMA_RD       = dma_rd;
    assign DMA_ADDR     = dma_rd ? {src_hi_q, idx_q} : 16'h0000;
    assign OAM_WR       = oam_wr;
    assign OAM_ADDR     = oam_wr ? (OAM_BASE_ADDR + {8'h00, idx_q}) : 16'h0000;
    assign OAM_DATA     = oam_wr ? data_q : 8'h00;
    assign DMA_ACTIVE   = (state_q == DMA_XFER);
    assign DMA_DONE     = done_q;
    assign MMIO_DATA_in = (ADDR == DMA_REG_ADDR) ? reg_q : 8'hFF;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl -- scoreboard bench for oam_dma_ctrl. Each trigger pushes the
// full list of expected OAM writes (address, data from a random source memory)
// and the expected DONE cycle; a monitor on the falling edge pops and compares.
module tb_oam_dma_ctrl;

    localparam int BYTES = 160;
    localparam int CPB   = 4;
    localparam int SDLY  = 4;
    localparam int TOTAL = SDLY + BYTES * CPB + 1;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ADDR;
    logic        WR;
    logic [7:0]  MMIO_DATA_out;
    logic [7:0]  MMIO_DATA_in;
    logic        DMA_RD;
    logic [15:0] DMA_ADDR;
    logic [7:0]  DMA_DATA_in;
    logic        OAM_WR;
    logic [15:0] OAM_ADDR;
    logic [7:0]  OAM_DATA;
    logic        DMA_ACTIVE;
    logic        DMA_DONE;

    logic [7:0]  mem [0:65535];
    wr_t         sb[$];
    wr_t         exp_w;
    logic [7:0]  exp_src = 8'h00;
    logic [15:0] last_wr_addr = 16'h0000;
    int          cyc = 0;
    int          exp_done_cyc = -1;
    int          trig_cyc = 0;
    int          done_seen = 0;
    int          wr_count = 0;
    int          rd_d3 = 0;
    int          rd_c1 = 0;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    oam_dma_ctrl #(.BYTES(BYTES), .CYC_PER_BYTE(CPB), .START_DLY(SDLY)) dut (
        .clk          (clk),
        .rst          (rst),
        .ADDR         (ADDR),
        .WR           (WR),
        .MMIO_DATA_out(MMIO_DATA_out),
        .MMIO_DATA_in (MMIO_DATA_in),
        .DMA_RD       (DMA_RD),
        .DMA_ADDR     (DMA_ADDR),
        .DMA_DATA_in  (DMA_DATA_in),
        .OAM_WR       (OAM_WR),
        .OAM_ADDR     (OAM_ADDR),
        .OAM_DATA     (OAM_DATA),
        .DMA_ACTIVE   (DMA_ACTIVE),
        .DMA_DONE     (DMA_DONE)
    );

    // Cycle counter and source memory: data returned one clock after DMA_RD.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (DMA_RD) DMA_DATA_in <= mem[DMA_ADDR];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT access against the scoreboard.
    always @(negedge clk) begin
        if (DMA_RD) begin
            if (DMA_ADDR[15:8] == 8'hD3) rd_d3++;
            if (DMA_ADDR[15:8] == 8'hC1) rd_c1++;
            if (sb.size() == 0) check("dma_rd_unexpected", 32'(DMA_RD), 0);
            else                check("dma_addr", 32'(DMA_ADDR), 32'({exp_src, sb[0].addr[7:0]}));
        end
        if (OAM_WR) begin
            wr_count++;
            last_wr_addr = OAM_ADDR;
            if (sb.size() == 0) check("oam_wr_unexpected", 32'(OAM_WR), 0);
            else begin
                exp_w = sb.pop_front();
                check("oam_addr", 32'(OAM_ADDR), 32'(exp_w.addr));
                check("oam_data", 32'(OAM_DATA), 32'(exp_w.data));
            end
        end
        if (cyc == exp_done_cyc) begin
            check("done_timing", 32'(DMA_DONE), 1);
            exp_done_cyc = -1;
        end else if (DMA_DONE) begin
            check("done_spurious", 32'(DMA_DONE), 0);
        end
        if (DMA_DONE) done_seen++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge: the write is presented for this cycle,
    // and the following rising edge is the trigger edge.
    task automatic start_trigger(input logic [7:0] v);
        wr_t w;
        ADDR = 16'hFF46;
        WR = 1'b1;
        MMIO_DATA_out = v;
        @(negedge clk);
        #1;
        sb.delete();
        exp_src = (v >= 8'hE0) ? v - 8'h20 : v;
        for (int i = 0; i < BYTES; i++) begin
            w.addr = 16'hFE00 + 16'(i);
            w.data = mem[{exp_src, 8'(i)}];
            sb.push_back(w);
        end
        trig_cyc = cyc + 1;
        exp_done_cyc = trig_cyc + TOTAL;
        @(posedge clk);
        #1;
        WR = 1'b0;
        ADDR = 16'h0000;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || exp_done_cyc != -1) && n < 2000) begin
            step(1);
            n++;
        end
        check({name, "_complete"}, 32'(sb.size() == 0 && exp_done_cyc == -1), 1);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_dma_rd"},     32'(DMA_RD), 0);
        check({name, "_oam_wr"},     32'(OAM_WR), 0);
        check({name, "_active"},     32'(DMA_ACTIVE), 0);
        check({name, "_done"},       32'(DMA_DONE), 0);
        check({name, "_dma_addr"},   32'(DMA_ADDR), 0);
        check({name, "_oam_addr"},   32'(OAM_ADDR), 0);
        check({name, "_oam_data"},   32'(OAM_DATA), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        int snap;
        logic [7:0] v;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        rst = 1'b0;
        WR = 1'b0;
        ADDR = 16'hFF46;
        MMIO_DATA_out = 8'h00;

        // Reset state.
        #1;
        check_outputs_zero("reset");
        check("reset_ff46", 32'(MMIO_DATA_in), 32'h00);
        step(3);
        @(negedge clk);
        rst = 1'b1;
        step(2);

        // Full transfer from page C1h.
        d0 = done_seen;
        start_trigger(8'hC1);
        step(300);
        check("c1_active_mid", 32'(DMA_ACTIVE), 1);
        wait_idle("c1");
        step(5);
        check("c1_done_count", 32'(done_seen - d0), 1);
        check("c1_active_idle", 32'(DMA_ACTIVE), 0);
        check("c1_last_wr", 32'(last_wr_addr), 32'hFE9F);

        // Echo fold: F3h reads page D3h.
        snap = rd_d3;
        start_trigger(8'hF3);
        wait_idle("f3");
        check("f3_reads_d3", 32'(rd_d3 - snap), BYTES);

        // Re-trigger at idx=50 with page 80h.
        d0 = done_seen;
        start_trigger(8'hC1);
        n = 0;
        while (sb.size() > BYTES - 50 && n < 1000) begin
            step(1);
            n++;
        end
        check("retrig_reach_idx50", 32'(sb.size()), BYTES - 50);
        start_trigger(8'h80);
        snap = rd_c1;
        wait_idle("retrig");
        step(5);
        check("retrig_no_c1_reads", 32'(rd_c1 - snap), 0);
        check("retrig_done_count", 32'(done_seen - d0), 1);

        // Trigger coincident with the final write.
        d0 = done_seen;
        start_trigger(8'($urandom));
        n = 0;
        while (cyc < trig_cyc + TOTAL - 1 && n < 1000) begin
            step(1);
            n++;
        end
        check("coinc_sync", 32'(sb.size()), 1);
        start_trigger(8'($urandom_range(0, 8'hDF)));
        check("coinc_fe9f_written", 32'(last_wr_addr), 32'hFE9F);
        check("coinc_done_low", 32'(DMA_DONE), 0);
        check("coinc_in_start", 32'(DMA_ACTIVE), 0);
        step(SDLY);
        check("coinc_still_start", 32'(DMA_ACTIVE), 0);
        step(1);
        check("coinc_xfer", 32'(DMA_ACTIVE), 1);
        wait_idle("coinc");
        step(5);
        check("coinc_done_count", 32'(done_seen - d0), 1);

        // Random pages with random restart points.
        repeat (5) begin
            v = 8'($urandom);
            start_trigger(v);
            step($urandom_range(1, 700));
        end
        wait_idle("rand");

        // Reset in the middle of XFER.
        start_trigger(8'hC1);
        step(100);
        rst = 1'b0;
        ADDR = 16'hFF46;
        #1;
        sb.delete();
        exp_done_cyc = -1;
        check_outputs_zero("midrst");
        check("midrst_ff46", 32'(MMIO_DATA_in), 32'h00);
        step(3);
        @(negedge clk);
        rst = 1'b1;
        d0 = done_seen;
        snap = wr_count;
        step(800);
        check("midrst_no_writes", 32'(wr_count - snap), 0);
        check("midrst_no_done", 32'(done_seen - d0), 0);
        ADDR = 16'hFF46;
        #1;
        check("midrst_ff46_after", 32'(MMIO_DATA_in), 32'h00);

        // Register readback.
        step(1);
        start_trigger(8'h7A);
        ADDR = 16'hFF46;
        #1;
        check("readback_ff46", 32'(MMIO_DATA_in), 32'h7A);
        ADDR = 16'hFF47;
        #1;
        check("readback_ff47", 32'(MMIO_DATA_in), 32'hFF);
        ADDR = 16'h0000;
        wait_idle("readback");

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 The block SHALL have parameter BYTES, default 160, giving the number of bytes copied into OAM.
REQ-002 The block SHALL have parameter CYC_PER_BYTE, default 4, giving the clocks per byte slot (minimum 3).
REQ-003 The block SHALL have parameter START_DLY, default 4, giving the clocks from trigger to the first byte slot.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port ADDR, input, 16 bits: CPU MMIO address.
REQ-007 The block SHALL have port WR, input, 1 bit: CPU write strobe.
REQ-008 The block SHALL have port MMIO_DATA_out, input, 8 bits: CPU write data.
REQ-009 The block SHALL have port MMIO_DATA_in, output, 8 bits: register readback.
REQ-010 The block SHALL have port DMA_RD, output, 1 bit: source read strobe.
REQ-011 The block SHALL have port DMA_ADDR, output, 16 bits: source address.
REQ-012 The block SHALL have port DMA_DATA_in, input, 8 bits: source data, valid one clock after DMA_RD.
REQ-013 The block SHALL have port OAM_WR, output, 1 bit: OAM write strobe.
REQ-014 The block SHALL have port OAM_ADDR, output, 16 bits: OAM write address.
REQ-015 The block SHALL have port OAM_DATA, output, 8 bits: OAM write data.
REQ-016 The block SHALL have port DMA_ACTIVE, output, 1 bit: high while in XFER; CPU/PPU OAM access is blocked while it is high.
REQ-017 The block SHALL have port DMA_DONE, output, 1 bit: one-clock pulse after the last byte is written.

Function
REQ-018 The block SHALL set register FF46 to MMIO_DATA_out when WR=1 and ADDR=FF46, with the update taking effect on the next edge (the trigger).
REQ-019 MMIO_DATA_in SHALL be FF46 when ADDR=FF46 and FFh otherwise, computed combinationally.
REQ-020 The state machine SHALL have states IDLE, START and XFER, and SHALL move IDLE->START on a trigger.
REQ-021 In START, a delay counter SHALL count START_DLY clocks, after which the block moves to XFER with idx=0 and phase=0.
REQ-022 In XFER, the phase counter SHALL cycle from 0 to CYC_PER_BYTE-1; each full cycle is one byte slot.
REQ-023 Phase 0 SHALL drive DMA_RD=1 and DMA_ADDR={src_hi, idx[7:0]}.
REQ-024 Phase 1 SHALL latch DMA_DATA_in into the data register.
REQ-025 Phase CYC_PER_BYTE-1 SHALL drive OAM_WR=1, OAM_ADDR=FE00h+idx and OAM_DATA=the data register, then increment idx.
REQ-026 DMA_RD SHALL be 0 outside phase 0 and OAM_WR SHALL be 0 outside the last phase, each being exactly one clock per slot.
REQ-027 src_hi SHALL equal FF46 if FF46<=DFh, and FF46-20h for E0h..FFh (echo fold), latched at the trigger.
REQ-028 idx SHALL be 8 bits; after the write at idx=BYTES-1 the block SHALL go XFER->IDLE and pulse DMA_DONE for exactly one clock.
REQ-029 A trigger while in START or XFER SHALL restart the transfer: new src_hi, idx=0, return to START, no OAM_WR issued in that clock, and no DMA_DONE for the aborted transfer.
REQ-030 A trigger in the same clock as the final write SHALL complete the write, suppress DMA_DONE and enter START.
REQ-031 Total clocks from the trigger edge to DMA_DONE high SHALL equal START_DLY+BYTES*CYC_PER_BYTE+1.

Reset
REQ-032 Asserting reset (rst=0) SHALL immediately set FF46=00h, state=IDLE and idx, phase and delay counters to 0.
REQ-033 During reset, DMA_RD, OAM_WR, DMA_ACTIVE and DMA_DONE SHALL be 0, and DMA_ADDR, OAM_ADDR and OAM_DATA SHALL be 0.
REQ-034 Reset mid-transfer SHALL abandon the transfer with no further writes and no DMA_DONE.

Structure
REQ-035 The shared ppu_pkg package SHALL hold the DMA_STATES_t enum {DMA_IDLE, DMA_START, DMA_XFER}, OAM_BASE_ADDR=FE00h and DMA_REG_ADDR=FF46h.
REQ-036 The block SHALL be a single module with no sub-module.

Verification
REQ-037 The bench SHALL verify: write C1h to FF46 with a memory model -> 160 OAM_WR at FE00..FE9F with data from C100..C19F, DMA_DONE exactly once at trigger+645 clocks.
REQ-038 The bench SHALL verify: write F3h -> DMA_ADDR high byte is D3h on every DMA_RD.
REQ-039 The bench SHALL verify: re-trigger with 80h at idx=50 -> no further C1xx reads, next write is at FE00 with data from 8000, one DMA_DONE only.
REQ-040 The bench SHALL verify: rst=0 asserted during XFER -> outputs zero the same clock, no OAM_WR afterwards, FF46 reads 00h.
REQ-041 The bench SHALL verify: read ADDR=FF46 after writing 7Ah -> 7Ah; read ADDR=FF47 -> FFh.
REQ-042 The bench SHALL verify: trigger coincident with the idx=159 write -> FE9F written, DMA_DONE stays 0, state=START.
